pipe_stage_register: RTL and testbench
======================================

PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- CTRL_W, 22: control payload width (one decode-to-execute control bundle).
- DATA_W, 175: datapath payload width (RD1, RD2, PC, Rs1, Rs2, Rd, ImmExt, PCPlus4).
- CTRL_BUBBLE, '0: control value loaded on flush and reset; encodes a NOP with no register write and no memory write.
- CNT_W, 32: performance counter width.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- Stall, in, 1: hold current contents.
- Flush, in, 1: replace contents with a bubble.
- ValidIn, in, 1: upstream stage holds a real instruction.
- CtrlIn, in, CTRL_W: upstream control bundle.
- DataIn, in, DATA_W: upstream datapath bundle.
- ValidOut, out, 1: registered valid.
- CtrlOut, out, CTRL_W: registered control.
- DataOut, out, DATA_W: registered datapath.
- PerfClr, in, 1: synchronous clear of both counters.
- StallCount, out, CNT_W: count of cycles stalled while holding a valid instruction.
- FlushCount, out, CNT_W: count of flushes that killed a valid instruction.

Function
REQ-003 On each clock edge, the register update SHALL follow this priority: Flush > Stall > load.
REQ-004 Load (Stall=0, Flush=0) SHALL set ValidOut<=ValidIn, CtrlOut<=CtrlIn and DataOut<=DataIn, with 1-cycle latency.
REQ-005 Stall=1 with Flush=0 SHALL hold ValidOut, CtrlOut and DataOut unchanged for any number of cycles.
REQ-006 Flush=1 SHALL set ValidOut<=0, CtrlOut<=CTRL_BUBBLE and DataOut<='0, regardless of Stall and ValidIn.
REQ-007 Load with ValidIn=0 SHALL force CtrlOut<=CTRL_BUBBLE, so an invalid slot never carries live control; DataOut still loads DataIn.
REQ-008 The outputs SHALL be driven directly from flops, with no combinational path from any input to ValidOut, CtrlOut or DataOut.
REQ-009 StallCount SHALL increment on each edge where Stall=1, Flush=0 and ValidOut=1.
REQ-010 FlushCount SHALL increment on each edge where Flush=1 and ValidOut=1.
REQ-011 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-012 PerfClr=1 SHALL clear both counters to 0 on that edge, overriding any increment in the same cycle.
REQ-013 The counters SHALL be observation-only and SHALL NOT affect the pipeline register path.

Reset
REQ-014 rst=1 SHALL immediately, without waiting for a clock edge, force: ValidOut=0, CtrlOut=CTRL_BUBBLE, DataOut=0, StallCount=0, FlushCount=0.
REQ-015 Asserting rst mid-stall or mid-flush SHALL discard the held instruction.
REQ-016 The first edge after rst deasserts SHALL follow REQ-003 normally.

Configuration
REQ-017 The macro PIPE_STAGE_PERF_EN SHALL control the performance counters.
- Defined: the counter logic of REQ-009 to REQ-012 is compiled in.
- Not defined: no counter flops exist, StallCount and FlushCount are tied to 0, and PerfClr is ignored.
- In both cases the register path (REQ-003 to REQ-008) SHALL be identical.

Verification
REQ-018 Reset check: assert rst asynchronously mid-cycle while ValidOut=1 and CtrlOut=0x155 -> ValidOut=0, CtrlOut=0 and DataOut=0 before the next edge.
REQ-019 Load check: ValidIn=1, CtrlIn=0x2AAAA, DataIn=0x1234, Stall=0, Flush=0 -> after 1 edge, ValidOut=1, CtrlOut=0x2AAAA, DataOut=0x1234.
REQ-020 Stall check: load A, then hold Stall=1 for 3 edges while DataIn=B -> DataOut=A throughout, and StallCount=3 (with macro defined).
REQ-021 Simultaneous check: Stall=1 and Flush=1 while ValidOut=1 -> next edge ValidOut=0, CtrlOut=CTRL_BUBBLE, and FlushCount increments by 1 while StallCount does not.
REQ-022 Invalid-slot check: ValidIn=0 with CtrlIn=0x3FFFFF -> CtrlOut=CTRL_BUBBLE and ValidOut=0.
REQ-023 Saturation check: with CNT_W=2, stall a valid instruction for 5 edges -> StallCount=3; then PerfClr=1 together with Stall=1 -> StallCount=0.

Source files
------------

// File: rtl/pipe_stage_register.sv
// rtl/pipe_stage_register.sv - decode-to-execute pipeline register with stall, flush and perf counters
//
// Purpose:
//   Registers one decode-to-execute bundle of valid, control and datapath fields.
//   Flush has priority over stall, and stall has priority over load.
//   An invalid slot always carries CTRL_BUBBLE control, so it cannot write the
//   register file or memory. Every output comes straight from a flop.
//
// Optional feature:
//   When PIPE_STAGE_PERF_EN is defined, the block includes saturating stall and flush counters.
//   When it is not defined, the counters are tied to 0 and PerfClr is ignored.
//
// Ports:
//   clk, rst       rising-edge clock and asynchronous active-high reset
//   Stall, Flush   hold the register or replace it with a bubble
//   ValidIn, CtrlIn, DataIn     upstream slot
//   ValidOut, CtrlOut, DataOut  registered slot
//   PerfClr        synchronous clear of both counters
//   StallCount     edges stalled while holding a valid instruction
//   FlushCount     flushes that killed a valid instruction

module pipe_stage_register #(
  parameter int                CTRL_W      = 22,
  parameter int                DATA_W      = 175,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ValidOut,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut,
  input  logic              PerfClr,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_data  <= '0;
    end else if (Flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_BUBBLE;
      r_data  <= '0;
    end else if (!Stall) begin
      r_valid <= ValidIn;
      // An invalid slot never carries live control. The data is loaded anyway.
      r_ctrl  <= ValidIn ? CtrlIn : CTRL_BUBBLE;
      r_data  <= DataIn;
    end
  end

  assign ValidOut = r_valid;
  assign CtrlOut  = r_ctrl;
  assign DataOut  = r_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_hit;
  logic             w_flush_hit;

  // The counters sample the registered valid, so they count the instruction
  // that is actually held or killed, not the instruction arriving from upstream.
  assign w_stall_hit = Stall && !Flush && r_valid;
  assign w_flush_hit = Flush && r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (PerfClr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      // Each counter saturates at all-ones instead of wrapping.
      if (w_stall_hit && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_hit && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
`else
  logic w_unused_perf_clr;

  assign w_unused_perf_clr = PerfClr;
  assign StallCount        = '0;
  assign FlushCount        = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// tb/tb_pipe_stage_register.sv - self-checking bench for pipe_stage_register
module tb_pipe_stage_register;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          Stall, Flush, ValidIn, PerfClr;
  logic [21:0]   CtrlIn;
  logic [174:0]  DataIn;
  logic          ValidOut;
  logic [21:0]   CtrlOut;
  logic [174:0]  DataOut;
  logic [31:0]   StallCount, FlushCount;
  logic          s_valid;
  logic [21:0]   s_ctrl;
  logic [174:0]  s_data;
  logic [1:0]    s_stall_cnt, s_flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_register dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .ValidOut(ValidOut), .CtrlOut(CtrlOut),
    .DataOut(DataOut), .PerfClr(PerfClr), .StallCount(StallCount),
    .FlushCount(FlushCount)
  );

  // A narrow-counter instance that shares all inputs, used for the saturation corner.
  pipe_stage_register #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .CtrlIn(CtrlIn), .DataIn(DataIn), .ValidOut(s_valid), .CtrlOut(s_ctrl),
    .DataOut(s_data), .PerfClr(PerfClr), .StallCount(s_stall_cnt),
    .FlushCount(s_flush_cnt)
  );

  typedef struct {
    logic         st, fl, vi;
    logic [21:0]  c;
    logic [174:0] d;
    logic         ev;
    logic [21:0]  ec;
    logic [174:0] ed;
  } vec_t;

  typedef struct {
    logic         ev;
    logic [21:0]  ec;
    logic [174:0] ed;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, {224'd0, act}, {224'd0, (PERF ? exp : 32'd0)});
  endtask

  // Drive one cycle of stimulus, push its expectation, then pop and compare after the edge.
  task automatic step(input string name, input logic st, input logic fl, input logic vi,
                      input logic [21:0] c, input logic [174:0] d, input logic pc,
                      input logic ev, input logic [21:0] ec, input logic [174:0] ed);
    exp_t e;
    Stall = st; Flush = fl; ValidIn = vi; CtrlIn = c; DataIn = d; PerfClr = pc;
    sb.push_back('{ev, ec, ed});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".valid"}, {255'd0, ValidOut}, {255'd0, e.ev});
      chk({name, ".ctrl"},  {234'd0, CtrlOut},  {234'd0, e.ec});
      chk({name, ".data"},  {81'd0, DataOut},   {81'd0, e.ed});
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".valid"}, {255'd0, ValidOut}, 256'd0);
    chk({name, ".ctrl"},  {234'd0, CtrlOut},  256'd0);
    chk({name, ".data"},  {81'd0, DataOut},   256'd0);
    chk_cnt({name, ".scnt"}, StallCount, 32'd0);
    chk_cnt({name, ".fcnt"}, FlushCount, 32'd0);
  endtask

  initial begin
    logic [174:0] ones;
    ones = '1;

    //            st    fl    vi    ctrl         data           ev    ectrl        edata
    tbl[0] = '{1'b0, 1'b0, 1'b1, 22'h2AAAA,  175'h1234,     1'b1, 22'h2AAAA,  175'h1234};  // load
    tbl[1] = '{1'b1, 1'b0, 1'b1, 22'h00001,  175'hBBBB,     1'b1, 22'h2AAAA,  175'h1234};  // stall
    tbl[2] = '{1'b1, 1'b0, 1'b1, 22'h00001,  175'hBBBB,     1'b1, 22'h2AAAA,  175'h1234};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 22'h00001,  175'hBBBB,     1'b1, 22'h2AAAA,  175'h1234};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 22'h00002,  175'hCCCC,     1'b0, 22'h0,      175'h0};     // stall and flush
    tbl[5] = '{1'b0, 1'b0, 1'b0, 22'h3FFFFF, 175'h5555,     1'b0, 22'h0,      175'h5555};  // invalid slot
    tbl[6] = '{1'b0, 1'b0, 1'b1, 22'h00155,  175'hABCD,     1'b1, 22'h00155,  175'hABCD};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 22'h00007,  175'h9,        1'b0, 22'h0,      175'h0};     // flush
    tbl[8] = '{1'b1, 1'b0, 1'b1, 22'h00008,  175'h8,        1'b0, 22'h0,      175'h0};     // stall an empty slot
    tbl[9] = '{1'b0, 1'b0, 1'b1, 22'h3FFFFF, ones,          1'b1, 22'h3FFFFF, ones};

    rst = 1'b1; Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b0; PerfClr = 1'b0;
    CtrlIn = '0; DataIn = '0;
    #1;
    chk_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("row%0d", i), tbl[i].st, tbl[i].fl, tbl[i].vi, tbl[i].c, tbl[i].d,
           1'b0, tbl[i].ev, tbl[i].ec, tbl[i].ed);
      if (i == 3) chk_cnt("stall3.scnt", StallCount, 32'd3);
      if (i == 4) begin
        chk_cnt("simul.fcnt", FlushCount, 32'd1);
        chk_cnt("simul.scnt", StallCount, 32'd3);
      end
      if (i == 8) chk_cnt("idle_stall.scnt", StallCount, 32'd3);
    end
    chk_cnt("after_tbl.fcnt", FlushCount, 32'd2);
    chk_cnt("sat_pre.scnt", {30'd0, s_stall_cnt}, 32'd3);

    // Saturation of the narrow counters, followed by a clear that overrides a stall.
    step("clr", 1'b0, 1'b0, 1'b1, 22'h11, 175'h11, 1'b1, 1'b1, 22'h11, 175'h11);
    chk_cnt("clr.scnt", StallCount, 32'd0);
    chk_cnt("clr.fcnt", FlushCount, 32'd0);
    for (int i = 0; i < 5; i++)
      step("sat_stall", 1'b1, 1'b0, 1'b1, 22'h22, 175'h22, 1'b0, 1'b1, 22'h11, 175'h11);
    chk_cnt("sat.scnt", {30'd0, s_stall_cnt}, 32'd3);
    chk_cnt("nosat.scnt", StallCount, 32'd5);
    step("clr_stall", 1'b1, 1'b0, 1'b1, 22'h22, 175'h22, 1'b1, 1'b1, 22'h11, 175'h11);
    chk_cnt("clr_stall.scnt", {30'd0, s_stall_cnt}, 32'd0);
    chk_cnt("clr_stall.wide", StallCount, 32'd0);

    // Asynchronous reset asserted mid-cycle while a 0x155 instruction is held.
    step("pre_rst", 1'b0, 1'b0, 1'b1, 22'h155, 175'h77, 1'b0, 1'b1, 22'h155, 175'h77);
    Stall = 1'b1;
    step("stall_hold", 1'b1, 1'b0, 1'b1, 22'h66, 175'h66, 1'b0, 1'b1, 22'h155, 175'h77);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("rst_edge");

    // The first edge after reset behaves normally.
    step("post_rst", 1'b0, 1'b0, 1'b1, 22'h33, 175'h33, 1'b0, 1'b1, 22'h33, 175'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
